edgcol_hb_sequencer: RTL and testbench
======================================

Name: edgcol_hb_sequencer

Overview:
- Hardware-block (HB) sequencer for the Xedgcol extension.
- Holds the edge endpoints written by the Xedgcol LI instruction (edgcolWrEna).
- On the HBStart pulse issued in DECODE of an ECOL instruction, it raster-walks every grid cell in the edge's bounding box. Each cell is checked through a valid/ready request to the collision-detect engine.
- It reports HBDone, which the main controller polls in EXECUTE, plus a hit result on execSrc.

Parameters:
- COORD_W, 4, bits per grid coordinate; grid is 2^COORD_W x 2^COORD_W.
- CNT_W, 2*COORD_W+1, width of the cells-checked counter; holds a full-grid count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- edgcolWrEna  in  1  load edge register from edge_wr_data.
- edge_wr_data  in  4*COORD_W  {x0,y0,x1,y1}, x0 in the MSBs.
- HBStart  in  1  one-cycle start pulse.
- HBDone  out  1  level; 1 = result valid.
- hb_hit  out  1  1 = occupied cell found.
- hb_hit_x, hb_hit_y  out  COORD_W each  first hit coordinate; 0 if no hit.
- hb_cells  out  CNT_W  number of responses consumed.
- cd_req_valid  out  1  cell-check request valid.
- cd_req_ready  in  1  engine accepts request.
- cd_req_x, cd_req_y  out  COORD_W each  cell under test.
- cd_resp_valid  in  1  engine response strobe.
- cd_resp_hit  in  1  cell occupied.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; edge register=0.
  - All outputs 0, including HBDone, hb_hit, hb_hit_x/y, hb_cells, cd_req_valid and cd_req_x/y.
  - No request remains outstanding; any in-flight engine response after reset is ignored.
- Edge load: edgcolWrEna=1 in IDLE or DONE latches edge_wr_data at the clock edge. It is ignored in SETUP/ISSUE/WAIT, where the register is frozen.
- State machine (all registered): IDLE, SETUP, ISSUE, WAIT, DONE.
  - IDLE/DONE, HBStart=1 -> SETUP.
    - Same edge: HBDone, hb_hit, hb_hit_x/y and hb_cells clear to 0.
    - HBDone therefore reads 0 in the first EXECUTE cycle.
  - SETUP -> ISSUE.
    - xmin=min(x0,x1), xmax=max(x0,x1), likewise for y.
    - cur_x=xmin, cur_y=ymin.
  - ISSUE:
    - cd_req_valid=1, with cd_req_x/y=cur_x/cur_y.
    - Request fields stay stable while ready=0.
    - On valid&ready -> WAIT.
  - WAIT: on cd_resp_valid, hb_cells increments.
    - resp_hit=1 -> DONE; hb_hit=1, hb_hit_x/y=cur.
    - Else cur==(xmax,ymax) -> DONE with hb_hit=0.
    - Else if cur_x==xmax: cur_x=xmin, cur_y+1.
    - Else cur_x+1.
    - Then -> ISSUE.
  - DONE: HBDone=1 and results held until the next HBStart.
- One outstanding request at most. A response arrives at least 1 cycle after acceptance; responses outside WAIT are ignored.
- Raster order: x inner, y outer, ascending.
- End-of-box is detected by equality before incrementing, so coordinate 2^COORD_W-1 never wraps.
- Minimum latency: HBStart in cycle 0 -> SETUP c1 -> ISSUE c2 (ready=1) -> WAIT c3 (resp) -> HBDone=1 in c4.
- Latency grows by 1 cycle per extra request-ready stall and per extra response-wait cycle.
- HBStart in SETUP/ISSUE/WAIT is ignored: no restart and no result clear.
- Simultaneous HBStart and edgcolWrEna in IDLE/DONE: the new edge is latched and then used by SETUP.
- Degenerate edge (x0==x1, y0==y1): exactly one request.

Test Plan:
- Single cell: edge {3,5,3,5}, HBStart, ready=1, resp next cycle with hit=0 -> one request (3,5); HBDone=1 exactly 4 cycles after HBStart; hb_hit=0; hb_cells=1.
- Box, no hits: edge {1,1,3,2} -> requests (1,1),(2,1),(3,1),(1,2),(2,2),(3,2) in order; hb_cells=6; hb_hit=0.
- Early exit and reversed endpoints:
  - Edge {3,2,1,1}, hit on 3rd response -> requests stop after (3,1).
  - hb_hit=1, hit_x=3, hit_y=1, hb_cells=3.
- Backpressure and boundary:
  - Edge {15,15,14,14}, ready low 3 cycles per request -> valid and x/y held stable while stalled.
  - 4 requests ending at (15,15); no wrap to 0; hb_cells=4.
- Busy robustness:
  - Extra HBStart and edgcolWrEna during WAIT -> ignored; results match the original edge.
  - Next HBStart clears HBDone on its edge.
- Reset mid-operation: rst_n low during WAIT -> all outputs 0 immediately, state IDLE; a late cd_resp_valid is ignored.

Source files
------------

// File: rtl/edgcol_hb_sequencer.sv
// Xedgcol hardware-block sequencer: raster-walks an edge's bounding box
// and queries the collision-detect engine one cell at a time.
module edgcol_hb_sequencer #(
    parameter int COORD_W = 4,
    parameter int CNT_W   = 2*COORD_W+1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 edgcolWrEna,
    input  logic [4*COORD_W-1:0] edge_wr_data,
    input  logic                 HBStart,
    output logic                 HBDone,
    output logic                 hb_hit,
    output logic [COORD_W-1:0]   hb_hit_x,
    output logic [COORD_W-1:0]   hb_hit_y,
    output logic [CNT_W-1:0]     hb_cells,
    output logic                 cd_req_valid,
    input  logic                 cd_req_ready,
    output logic [COORD_W-1:0]   cd_req_x,
    output logic [COORD_W-1:0]   cd_req_y,
    input  logic                 cd_resp_valid,
    input  logic                 cd_resp_hit
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [4*COORD_W-1:0] edge_q;
    logic [COORD_W-1:0]   xmin;
    logic [COORD_W-1:0]   xmax;
    logic [COORD_W-1:0]   ymin;
    logic [COORD_W-1:0]   ymax;
    logic [COORD_W-1:0]   cur_x;
    logic [COORD_W-1:0]   cur_y;

    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;

    logic idle_like;
    logic start;
    logic resp;
    logic last_cell;
    logic row_end;

    assign x0 = edge_q[4*COORD_W-1:3*COORD_W];
    assign y0 = edge_q[3*COORD_W-1:2*COORD_W];
    assign x1 = edge_q[2*COORD_W-1:COORD_W];
    assign y1 = edge_q[COORD_W-1:0];

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign start     = idle_like && HBStart;
    assign resp      = (state_q == WAIT) && cd_resp_valid;
    assign row_end   = (cur_x == xmax);
    // End of box is found by equality so the top coordinate never wraps
    assign last_cell = row_end && (cur_y == ymax);

    assign HBDone       = (state_q == DONE);
    assign cd_req_valid = (state_q == ISSUE);
    assign cd_req_x     = cur_x;
    assign cd_req_y     = cur_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (HBStart) state_d = SETUP;
            end
            SETUP: state_d = ISSUE;
            ISSUE: begin
                if (cd_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (cd_resp_valid) begin
                    if (cd_resp_hit || last_cell) state_d = DONE;
                    else state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q   <= '0;
            xmin     <= '0;
            xmax     <= '0;
            ymin     <= '0;
            ymax     <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            hb_hit   <= 1'b0;
            hb_hit_x <= '0;
            hb_hit_y <= '0;
            hb_cells <= '0;
        end else begin
            // Edge register is frozen while a walk is in progress
            if (idle_like && edgcolWrEna) begin
                edge_q <= edge_wr_data;
            end
            if (start) begin
                hb_hit   <= 1'b0;
                hb_hit_x <= '0;
                hb_hit_y <= '0;
                hb_cells <= '0;
            end
            if (state_q == SETUP) begin
                xmin  <= (x0 < x1) ? x0 : x1;
                xmax  <= (x0 < x1) ? x1 : x0;
                ymin  <= (y0 < y1) ? y0 : y1;
                ymax  <= (y0 < y1) ? y1 : y0;
                cur_x <= (x0 < x1) ? x0 : x1;
                cur_y <= (y0 < y1) ? y0 : y1;
            end
            if (resp) begin
                hb_cells <= hb_cells + CNT_W'(1);
                if (cd_resp_hit) begin
                    hb_hit   <= 1'b1;
                    hb_hit_x <= cur_x;
                    hb_hit_y <= cur_y;
                end else if (!last_cell) begin
                    if (row_end) begin
                        cur_x <= xmin;
                        cur_y <= cur_y + COORD_W'(1);
                    end else begin
                        cur_x <= cur_x + COORD_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_edgcol_hb_sequencer.sv
// Self-checking bench for edgcol_hb_sequencer: engine model plus
// request/result scoreboard queues.
module tb_edgcol_hb_sequencer;

    logic        clk;
    logic        rst_n;
    logic        edgcolWrEna;
    logic [15:0] edge_wr_data;
    logic        HBStart;
    logic        HBDone;
    logic        hb_hit;
    logic [3:0]  hb_hit_x;
    logic [3:0]  hb_hit_y;
    logic [8:0]  hb_cells;
    logic        cd_req_valid;
    logic        cd_req_ready;
    logic [3:0]  cd_req_x;
    logic [3:0]  cd_req_y;
    logic        cd_resp_valid;
    logic        cd_resp_hit;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  req_q[$];
    logic [17:0] res_q[$];
    logic [15:0] model_edge;

    edgcol_hb_sequencer #(.COORD_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .edgcolWrEna(edgcolWrEna),
        .edge_wr_data(edge_wr_data),
        .HBStart(HBStart),
        .HBDone(HBDone),
        .hb_hit(hb_hit),
        .hb_hit_x(hb_hit_x),
        .hb_hit_y(hb_hit_y),
        .hb_cells(hb_cells),
        .cd_req_valid(cd_req_valid),
        .cd_req_ready(cd_req_ready),
        .cd_req_x(cd_req_x),
        .cd_req_y(cd_req_y),
        .cd_resp_valid(cd_resp_valid),
        .cd_resp_hit(cd_resp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] all_outs();
        return {HBDone, hb_hit, hb_hit_x, hb_hit_y, hb_cells,
                cd_req_valid, cd_req_x, cd_req_y};
    endfunction

    // Push expected requests/results for an edge, stopping at the hit index
    task automatic plan(input logic [15:0] ed, input int hit_idx);
        int x0, y0, x1, y1, xa, xb, ya, yb, cnt;
        logic hit;
        logic [3:0] hx, hy;
        x0 = int'(ed[15:12]); y0 = int'(ed[11:8]);
        x1 = int'(ed[7:4]);   y1 = int'(ed[3:0]);
        xa = (x0 < x1) ? x0 : x1; xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1; yb = (y0 < y1) ? y1 : y0;
        cnt = 0; hit = 1'b0; hx = 4'd0; hy = 4'd0;
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                if (!hit) begin
                    req_q.push_back({4'(x), 4'(y)});
                    cnt++;
                    if (cnt == hit_idx) begin
                        hit = 1'b1; hx = 4'(x); hy = 4'(y);
                    end
                end
            end
        end
        res_q.push_back({hit, hx, hy, 9'(cnt)});
    endtask

    task automatic run(input logic [15:0] ed, input bit load,
                       input int hit_idx, input int stall, input int gap,
                       input bit poke, input int exp_lat);
        int cyc, sc, gc, n;
        bit done, seen, waiting;
        logic [3:0] hx, hy;
        logic [7:0] er;
        logic [17:0] eres;
        if (load) model_edge = ed;
        plan(model_edge, hit_idx);
        @(negedge clk);
        if (load) begin
            edgcolWrEna = 1'b1;
            edge_wr_data = ed;
        end
        HBStart = 1'b1;
        cyc = 0; sc = 0; gc = 0; n = 0;
        done = 0; seen = 0; waiting = 0;
        hx = 4'd0; hy = 4'd0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            HBStart = 1'b0; edgcolWrEna = 1'b0;
            cd_req_ready = 1'b0; cd_resp_valid = 1'b0; cd_resp_hit = 1'b0;
            if (cyc == 1) check("done_clear", 32'(HBDone), 32'd0);
            if (HBDone) begin
                done = 1;
            end else if (waiting) begin
                if (poke && n == 1 && gc == gap) begin
                    HBStart = 1'b1;
                    edgcolWrEna = 1'b1;
                    edge_wr_data = 16'h00ff;
                end
                if (gc == 0) begin
                    cd_resp_valid = 1'b1;
                    cd_resp_hit = (n == hit_idx);
                    waiting = 0;
                end else begin
                    gc--;
                end
            end else if (seen || cd_req_valid) begin
                if (!seen) begin
                    seen = 1; hx = cd_req_x; hy = cd_req_y;
                end
                check("req_hold", 32'({cd_req_valid, cd_req_x, cd_req_y}),
                      32'({1'b1, hx, hy}));
                if (sc < stall) begin
                    sc++;
                end else begin
                    cd_req_ready = 1'b1;
                    if (req_q.size() == 0) begin
                        check("extra_req", 32'({cd_req_x, cd_req_y}), 32'hffff);
                    end else begin
                        er = req_q.pop_front();
                        check("req_xy", 32'({cd_req_x, cd_req_y}), 32'(er));
                    end
                    n++; waiting = 1; gc = gap; sc = 0; seen = 0;
                end
            end
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            if (exp_lat > 0) check("latency", 32'(cyc), 32'(exp_lat));
            eres = res_q.pop_front();
            check("hit", 32'(hb_hit), 32'(eres[17]));
            check("hit_xy", 32'({hb_hit_x, hb_hit_y}), 32'(eres[16:9]));
            check("cells", 32'(hb_cells), 32'(eres[8:0]));
        end
        check("req_left", 32'(req_q.size()), 32'd0);
        req_q.delete();
        res_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        edgcolWrEna = 1'b0; edge_wr_data = 16'h0; HBStart = 1'b0;
        cd_req_ready = 1'b0; cd_resp_valid = 1'b0; cd_resp_hit = 1'b0;
        model_edge = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outs", 32'(all_outs()), 32'd0);

        run(16'h3535, 1, 0, 0, 0, 0, 4);
        run(16'h1132, 1, 0, 0, 1, 0, 0);
        run(16'h3211, 1, 3, 0, 0, 0, 0);
        run(16'hffee, 1, 0, 3, 0, 0, 0);
        run(16'hffee, 1, 4, 1, 2, 0, 0);
        run(16'h2324, 1, 0, 0, 2, 1, 0);
        run(16'h0000, 0, 0, 0, 0, 0, 0);
        run(16'h5a5a, 1, 1, 0, 0, 0, 4);

        // Reset in WAIT, then a stale response
        @(negedge clk);
        edgcolWrEna = 1'b1; edge_wr_data = 16'h0020; HBStart = 1'b1;
        @(negedge clk);
        edgcolWrEna = 1'b0; HBStart = 1'b0;
        @(negedge clk);
        check("rst_req_valid", 32'(cd_req_valid), 32'd1);
        cd_req_ready = 1'b1;
        @(negedge clk);
        cd_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cd_resp_valid = 1'b1; cd_resp_hit = 1'b1;
        @(negedge clk);
        cd_resp_valid = 1'b0; cd_resp_hit = 1'b0;
        @(negedge clk);
        check("late_resp", 32'(all_outs()), 32'd0);
        model_edge = 16'h0;
        run(16'h0000, 0, 0, 0, 0, 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
